imem_loader: RTL and testbench

//  Dual-instruction memory that feeds the core's 64-bit fetch port (addr_o/data_i/imemstall_o/imem_sr_o).
//  At boot it accepts a byte-serial program image and packs it into 64-bit words.
//  It then releases the core and serves synchronous-read fetch pairs {inst1,inst0}, with hold and flush.

---
 rtl/imem_loader_if.sv | 25 ++
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Loader/fetch bundle between the boot byte stream, the core fetch port and imem_loader.
// The slave modport is the memory side; the master modport is the source/core side.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        rx_data_i;
    logic              rx_valid_i;
    logic              rx_ready_o;
    logic              core_run_o;
    logic [ADDR_W:0]   words_loaded_o;
    logic [ADDR_W-1:0] addr_i;
    logic              hold_i;
    logic              sr_i;
    logic [63:0]       data_o;

    modport slave (
        input  rx_data_i, rx_valid_i, addr_i, hold_i, sr_i,
        output rx_ready_o, core_run_o, words_loaded_o, data_o
    );

    modport master (
        output rx_data_i, rx_valid_i, addr_i, hold_i, sr_i,
        input  rx_ready_o, core_run_o, words_loaded_o, data_o
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-loaded instruction memory: packs a length-prefixed byte image into 64-bit words,
// then releases the core and serves synchronous fetch pairs with hold and flush.
module imem_loader #(
    parameter int          DEPTH  = 1024,
    parameter int          ADDR_W = 10,
    parameter logic [63:0] NOP    = 64'h00000013_00000013
) (
    input  logic          clock_i,
    input  logic          reset_i,
    imem_loader_if.slave  bus
);
    typedef enum logic [1:0] {
        HDR_LO = 2'd0,
        HDR_HI = 2'd1,
        LOAD   = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic [63:0]       mem [DEPTH];

    state_t            state_q, state_d;
    logic [7:0]        count_lo_q, count_lo_d;
    logic [ADDR_W:0]   eff_q, eff_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [55:0]       shift_q, shift_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
    logic              core_run_q;
    logic [63:0]       data_q;

    logic              rx_ready_s;
    logic              accept_s;
    logic [15:0]       hdr_count_s;
    logic [ADDR_W:0]   eff_s;
    logic              wr_en_s;
    logic [63:0]       wr_data_s;

    assign rx_ready_s = (state_q != RUN) & ~reset_i;
    assign accept_s   = bus.rx_valid_i & rx_ready_s;

    // Loader next-state: header capture, byte packing and word commit.
    always_comb begin
        state_d        = state_q;
        count_lo_d     = count_lo_q;
        eff_d          = eff_q;
        byte_cnt_d     = byte_cnt_q;
        shift_d        = shift_q;
        word_addr_d    = word_addr_q;
        words_loaded_d = words_loaded_q;
        wr_en_s        = 1'b0;
        wr_data_s      = {bus.rx_data_i, shift_q};
        hdr_count_s    = {bus.rx_data_i, count_lo_q};
        eff_s          = ({1'b0, hdr_count_s} > 17'(DEPTH)) ? DEPTH_C : hdr_count_s[ADDR_W:0];

        case (state_q)
            HDR_LO: begin
                if (accept_s) begin
                    count_lo_d = bus.rx_data_i;
                    state_d    = HDR_HI;
                end else begin
                    state_d    = HDR_LO;
                end
            end
            HDR_HI: begin
                if (accept_s) begin
                    eff_d      = eff_s;
                    byte_cnt_d = 3'd0;
                    state_d    = (eff_s == '0) ? RUN : LOAD;
                end else begin
                    state_d    = HDR_HI;
                end
            end
            LOAD: begin
                if (accept_s && (byte_cnt_q == 3'd7)) begin
                    wr_en_s        = 1'b1;
                    byte_cnt_d     = 3'd0;
                    word_addr_d    = word_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    words_loaded_d = words_loaded_q + {{ADDR_W{1'b0}}, 1'b1};
                    if ((words_loaded_q + {{ADDR_W{1'b0}}, 1'b1}) == eff_q) begin
                        state_d = RUN;
                    end else begin
                        state_d = LOAD;
                    end
                end else if (accept_s) begin
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    shift_d    = {bus.rx_data_i, shift_q[55:8]};
                end else begin
                    state_d    = LOAD;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = HDR_LO;
        endcase
    end

    // Loader state registers; a reset mid-load drops any partial word.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= HDR_LO;
            count_lo_q     <= 8'd0;
            eff_q          <= '0;
            byte_cnt_q     <= 3'd0;
            shift_q        <= 56'd0;
            word_addr_q    <= '0;
            words_loaded_q <= '0;
            core_run_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_lo_q     <= count_lo_d;
            eff_q          <= eff_d;
            byte_cnt_q     <= byte_cnt_d;
            shift_q        <= shift_d;
            word_addr_q    <= word_addr_d;
            words_loaded_q <= words_loaded_d;
            core_run_q     <= (state_d == RUN);
        end
    end

    // Memory write port; contents survive reset so a re-load overwrites in place.
    always_ff @(posedge clock_i) begin
        if (wr_en_s) begin
            mem[word_addr_q] <= wr_data_s;
        end
    end

    // Fetch register: reset > outside RUN > flush > hold > read.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            data_q <= NOP;
        end else if (state_q != RUN) begin
            data_q <= NOP;
        end else if (bus.sr_i) begin
            data_q <= NOP;
        end else if (bus.hold_i) begin
            data_q <= data_q;
        end else begin
            data_q <= mem[bus.addr_i];
        end
    end

    assign bus.rx_ready_o     = rx_ready_s;
    assign bus.core_run_o     = core_run_q;
    assign bus.words_loaded_o = words_loaded_q;
    assign bus.data_o         = data_q;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a byte-count based reference model is checked every cycle,
// with literal expectations from the boot image examples pinning the model.
module tb_imem_loader;
    localparam logic [63:0] NOP = 64'h00000013_00000013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(10)) bus();

    imem_loader #(.DEPTH(1024), .ADDR_W(10), .NOP(NOP)) dut (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model: everything derived from the number of bytes accepted since reset
    int          m_nacc;
    logic [15:0] m_count;
    int          m_eff;
    int          m_wl;
    bit          m_run;
    logic [63:0] m_cur;
    logic [63:0] m_mem [1024];
    bit          m_known [1024];
    logic [63:0] m_data;
    bit          m_data_known;
    int          dut_hs = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
    end

    always @(posedge clk) begin
        bit pr;
        int k;
        if (bus.rx_valid_i && bus.rx_ready_o) dut_hs++;
        if (rst) begin
            m_nacc = 0; m_wl = 0; m_eff = 0; m_run = 1'b0;
            m_data = NOP; m_data_known = 1'b1;
        end else begin
            pr = m_run;
            if (!pr || bus.sr_i) begin
                m_data = NOP; m_data_known = 1'b1;
            end else if (!bus.hold_i) begin
                m_data = m_mem[bus.addr_i]; m_data_known = m_known[bus.addr_i];
            end
            if (bus.rx_valid_i && !pr) begin
                m_nacc++;
                if (m_nacc == 1) begin
                    m_count[7:0] = bus.rx_data_i;
                end else if (m_nacc == 2) begin
                    m_count[15:8] = bus.rx_data_i;
                    m_eff = (int'(m_count) > 1024) ? 1024 : int'(m_count);
                    if (m_eff == 0) m_run = 1'b1;
                end else begin
                    k = (m_nacc - 3) % 8;
                    m_cur[k*8 +: 8] = bus.rx_data_i;
                    if (k == 7) begin
                        m_mem[m_wl] = m_cur; m_known[m_wl] = 1'b1;
                        m_wl++;
                        if (m_wl == m_eff) m_run = 1'b1;
                    end
                end
            end
        end
    end

    // per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        chk("rx_ready", {63'd0, bus.rx_ready_o}, {63'd0, (!m_run && !rst)});
        chk("core_run", {63'd0, bus.core_run_o}, {63'd0, m_run});
        chk("words_loaded", {53'd0, bus.words_loaded_o}, 64'(m_wl));
        if (m_data_known) chk("data", bus.data_o, m_data);
    end

    task automatic tx(input logic [7:0] b);
        bus.rx_data_i  = b;
        bus.rx_valid_i = 1'b1;
        @(negedge clk);
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a);
        bus.addr_i = a; bus.hold_i = 1'b0; bus.sr_i = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0]  img1 [16];
    logic [7:0]  ab [20];
    logic [7:0]  nb [8];
    logic [63:0] w_exp;
    int          guard;

    initial begin
        img1 = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00,
                 8'h13, 8'h06, 8'h30, 8'h00, 8'h93, 8'h06, 8'h40, 8'h00};
        rst = 1'b1;
        bus.rx_data_i = 8'd0; bus.rx_valid_i = 1'b0;
        bus.addr_i = 10'd0; bus.hold_i = 1'b0; bus.sr_i = 1'b0;
        idle(3);
        rst = 1'b0;
        chk("reset_data", bus.data_o, NOP);
        chk("reset_words", {53'd0, bus.words_loaded_o}, 64'd0);
        idle(1);
        chk("ready_after_reset", {63'd0, bus.rx_ready_o}, 64'd1);

        // two-word image with a gap
        tx(8'h02); idle(2); tx(8'h00);
        for (int i = 0; i < 15; i++) tx(img1[i]);
        chk("t1_run_before_last", {63'd0, bus.core_run_o}, 64'd0);
        tx(img1[15]);
        chk("t1_run_after_last", {63'd0, bus.core_run_o}, 64'd1);
        chk("t1_words", {53'd0, bus.words_loaded_o}, 64'd2);

        rd(10'd1);
        chk("t2_read1", bus.data_o, 64'h00400693_00300613);
        bus.addr_i = 10'd0; bus.hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_hold", bus.data_o, 64'h00400693_00300613);
        end

        bus.sr_i = 1'b1; bus.hold_i = 1'b1; bus.addr_i = 10'd0;
        @(negedge clk);
        chk("t3_flush", bus.data_o, NOP);
        rd(10'd0);
        chk("t3_read0", bus.data_o, 64'h00200593_00100513);

        // empty image
        pulse_reset();
        tx(8'h00); tx(8'h00);
        chk("t4_run", {63'd0, bus.core_run_o}, 64'd1);
        chk("t4_words", {53'd0, bus.words_loaded_o}, 64'd0);
        chk("t4_ready", {63'd0, bus.rx_ready_o}, 64'd0);
        tx(8'h55);

        // oversized image, clamped to full depth
        pulse_reset();
        tx(8'hFF); tx(8'hFF);
        guard = 0;
        dut_hs = 0;
        while (!bus.core_run_o && guard < 40000) begin
            bus.addr_i = 10'($urandom);
            tx(8'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            guard++;
        end
        chk("t6_bytes", 64'(dut_hs), 64'(8192));
        chk("t6_words", {53'd0, bus.words_loaded_o}, 64'd1024);
        for (int i = 0; i < 300; i++) begin
            bus.addr_i = 10'($urandom);
            bus.hold_i = ($urandom_range(0, 3) == 0);
            bus.sr_i   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1) begin
                tx(8'($urandom));
            end else begin
                @(negedge clk);
            end
        end
        chk("t6_no_more_hs", 64'(dut_hs), 64'(8192));
        bus.hold_i = 1'b0; bus.sr_i = 1'b0;

        // aborted load, byte in the reset cycle, then a one-word reload
        pulse_reset();
        ab[0] = 8'h05; ab[1] = 8'h00;
        for (int i = 2; i < 20; i++) ab[i] = 8'($urandom);
        for (int i = 0; i < 20; i++) tx(ab[i]);
        rst = 1'b1; bus.rx_valid_i = 1'b1; bus.rx_data_i = 8'h01;
        @(negedge clk);
        rst = 1'b0; bus.rx_valid_i = 1'b0;
        chk("t5_run_cleared", {63'd0, bus.core_run_o}, 64'd0);
        chk("t5_data_nop", bus.data_o, NOP);
        chk("t5_words_cleared", {53'd0, bus.words_loaded_o}, 64'd0);
        tx(8'h01); tx(8'h00);
        for (int i = 0; i < 8; i++) begin
            nb[i] = 8'($urandom);
            tx(nb[i]);
        end
        chk("t5_run", {63'd0, bus.core_run_o}, 64'd1);
        chk("t5_words", {53'd0, bus.words_loaded_o}, 64'd1);
        rd(10'd0);
        for (int i = 0; i < 8; i++) w_exp[i*8 +: 8] = nb[i];
        chk("t5_word0_new", bus.data_o, w_exp);
        rd(10'd1);
        for (int i = 0; i < 8; i++) w_exp[i*8 +: 8] = ab[10 + i];
        chk("t5_word1_old", bus.data_o, w_exp);
        rd(10'd2);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
